// File: rtl/cl_mem_arbiter_pkg.sv
// Shared definitions for the cache-line memory arbiter: FSM state and
// owner encodings, the default watchdog limit and a small owner helper.
package cl_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int DEF_XLEN           = 64;
  localparam int DEF_CLSIZE         = 256;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // The requester that is not `o`; used to advance the round-robin pointer.
  function automatic owner_e other_side(input owner_e o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/cl_mem_arbiter_if.sv
// Bundle of the I-side, D-side and memory-side line ports of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (caches, atomic unit and memory controller together).
interface cl_mem_arbiter_if #(
  parameter int XLEN   = 64,
  parameter int CLSIZE = 256
);
  // I-cache refill path (read only)
  logic              i_strobe_i;
  logic [XLEN-1:0]   i_addr_i;
  logic              i_done_o;
  logic [CLSIZE-1:0] i_data_o;
  // D-cache / atomic unit path
  logic              d_strobe_i;
  logic [XLEN-1:0]   d_addr_i;
  logic              d_rw_i;
  logic [CLSIZE-1:0] d_data_i;
  logic              d_done_o;
  logic [CLSIZE-1:0] d_data_o;
  // Memory controller line port
  logic              m_strobe_o;
  logic [XLEN-1:0]   m_addr_o;
  logic              m_rw_o;
  logic [CLSIZE-1:0] m_data_o;
  logic              m_done_i;
  logic [CLSIZE-1:0] m_data_i;

  modport slave (
    input  i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i,
           m_done_i, m_data_i,
    output i_done_o, i_data_o, d_done_o, d_data_o,
           m_strobe_o, m_addr_o, m_rw_o, m_data_o
  );

  modport master (
    output i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i,
           m_done_i, m_data_i,
    input  i_done_o, i_data_o, d_done_o, d_data_o,
           m_strobe_o, m_addr_o, m_rw_o, m_data_o
  );
endinterface

// File: rtl/cl_arb_pick.sv
// Two-input grant selector. With MEM_ARB_RR_EN defined it arbitrates
// round-robin using a pointer to the side favoured on the next tie; without
// it, D has fixed priority over I and no state is kept.
module cl_arb_pick
  import cl_mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   grant_en,
`endif
  input  logic   i_req,
  input  logic   d_req,
  output owner_e winner
);

`ifdef MEM_ARB_RR_EN
  owner_e rr_q;

  // Tie goes to the pointed-at side; a lone requester always wins.
  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    winner = OWN_D;
    if (i_req && d_req) winner = rr_q;
    else if (i_req)     winner = OWN_I;
    else if (d_req)     winner = OWN_D;
  end

  // Pointer moves to the loser of each grant, so the next tie favours it.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        rr_q <= OWN_I;
    else if (grant_en) rr_q <= other_side(winner);
  end
`else
  // Fixed priority: D first; I only when D is idle.
  always_comb begin
    winner = OWN_D;
    if (d_req)      winner = OWN_D;
    else if (i_req) winner = OWN_I;
  end
`endif

endmodule

// File: rtl/cl_mem_arbiter.sv
// Two-port cache-line memory arbiter: serialises I-refill and D-side line
// transactions onto one memory port, routes completion and read data back to
// the granted side only, and raises a sticky watchdog flag when the memory
// port stays outstanding too long. Arbitration policy selected by
// MEM_ARB_RR_EN (round-robin when defined, D-over-I fixed priority otherwise).
module cl_mem_arbiter
  import cl_mem_arbiter_pkg::*;
#(
  parameter int XLEN           = DEF_XLEN,
  parameter int CLSIZE         = DEF_CLSIZE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  cl_mem_arbiter_if.slave bus,
  output logic            timeout_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, winner;
  logic              any_req, grant;
  logic              m_strobe, i_done, d_done;
  logic [XLEN-1:0]   m_addr_q;
  logic              m_rw_q;
  logic [CLSIZE-1:0] m_data_q, i_data_q, d_data_q;

  assign any_req = bus.i_strobe_i | bus.d_strobe_i;
  assign grant   = (state_q == IDLE) && any_req;

  cl_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .grant_en (grant),
`endif
    .i_req    (bus.i_strobe_i),
    .d_req    (bus.d_strobe_i),
    .winner   (winner)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; RESP never grants, giving the owner a
  // cycle to drop its strobe.
  always_comb begin
    state_d  = state_q;
    m_strobe = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    unique case (state_q)
      IDLE:  if (any_req) state_d = ISSUE;
      ISSUE: begin
        m_strobe = 1'b1;
        if (bus.m_done_i) state_d = RESP;
      end
      RESP: begin
        i_done  = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch: requester inputs are only sampled at the grant edge.
  // NOTE: wide data registers get a reset too, since they drive ports whose
  // reset value is observable; there is no storage array here to leave unreset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q  <= OWN_I;
      m_addr_q <= '0;
      m_rw_q   <= 1'b0;
      m_data_q <= '0;
    end else if (grant) begin
      owner_q <= winner;
      if (winner == OWN_D) begin
        m_addr_q <= bus.d_addr_i;
        m_rw_q   <= bus.d_rw_i;
        m_data_q <= bus.d_data_i;
      end else begin
        m_addr_q <= bus.i_addr_i;
        m_rw_q   <= 1'b0;
        m_data_q <= '0;
      end
    end
  end

  // Response capture into the owner's register; m_done_i outside ISSUE is ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      i_data_q <= '0;
      d_data_q <= '0;
    end else if ((state_q == ISSUE) && bus.m_done_i) begin
      if (owner_q == OWN_D) d_data_q <= bus.m_data_i;
      else                  i_data_q <= bus.m_data_i;
    end
  end

  assign bus.m_strobe_o = m_strobe;
  assign bus.m_addr_o   = m_addr_q;
  assign bus.m_rw_o     = m_rw_q;
  assign bus.m_data_o   = m_data_q;
  assign bus.i_done_o   = i_done;
  assign bus.i_data_o   = i_data_q;
  assign bus.d_done_o   = d_done;
  assign bus.d_data_o   = d_data_q;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt_q;
      logic          timeout_q;

      // Watchdog: restart at each grant, count ISSUE cycles without
      // completion, set the sticky flag at the limit; no abort.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt_q     <= '0;
          timeout_q <= 1'b0;
        end else if (grant) begin
          cnt_q <= '0;
        end else if ((state_q == ISSUE) && !bus.m_done_i && !timeout_q) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
          else                                  cnt_q     <= cnt_q + CW'(1);
        end
      end

      assign timeout_o = timeout_q;
    end else begin : g_no_wdog
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cl_mem_arbiter.sv
// Self-checking bench for cl_mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model. The
// arbitration expectation follows MEM_ARB_RR_EN in the same way as the design.
module tb_cl_mem_arbiter;

  localparam int XLEN = 64;
  localparam int CL   = 256;
  localparam int TO   = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic timeout_o;

  cl_mem_arbiter_if #(.XLEN(XLEN), .CLSIZE(CL)) bus ();

  cl_mem_arbiter #(.XLEN(XLEN), .CLSIZE(CL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run;
  int fails;

  // Reference model state: pending requests and their values, last served
  // side (round-robin only), last delivered lines, expected watchdog flag.
  logic [XLEN-1:0] req_i_addr, req_d_addr;
  logic            req_d_rw;
  logic [CL-1:0]   req_d_data;
  bit              i_pend, d_pend;
`ifdef MEM_ARB_RR_EN
  bit              last_d;
`endif
  logic [CL-1:0]   last_i_rd, last_d_rd;
  bit              exp_to;

  function automatic logic [CL-1:0] rand_line();
    logic [CL-1:0] r;
    for (int k = 0; k < CL / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [XLEN-1:0] rand_addr();
    logic [XLEN-1:0] a;
    a = {$urandom(), $urandom()};
    return a & ~(XLEN'(63));
  endfunction

  // Which side the arbitration rule grants given the pending set.
  function automatic bit model_pick_d(input bit ip, input bit dp);
    if (ip && dp) begin
`ifdef MEM_ARB_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return dp;
  endfunction

  function automatic void model_reset();
`ifdef MEM_ARB_RR_EN
    last_d = 1'b1;
`endif
    last_i_rd = '0;
    last_d_rd = '0;
    exp_to    = 1'b0;
    i_pend    = 1'b0;
    d_pend    = 1'b0;
  endfunction

  task automatic raise_i(input logic [XLEN-1:0] a);
    req_i_addr     = a;
    i_pend         = 1'b1;
    bus.i_addr_i   = a;
    bus.i_strobe_i = 1'b1;
  endtask

  task automatic raise_d(input logic [XLEN-1:0] a, input logic rw, input logic [CL-1:0] d);
    req_d_addr     = a;
    req_d_rw       = rw;
    req_d_data     = d;
    d_pend         = 1'b1;
    bus.d_addr_i   = a;
    bus.d_rw_i     = rw;
    bus.d_data_i   = d;
    bus.d_strobe_i = 1'b1;
  endtask

  // Carry one pending request through grant, ISSUE (lat extra cycles), RESP.
  // Starts and ends on a falling edge with the design in IDLE.
  task automatic serve_one(input int lat, input logic [CL-1:0] rd, output bit won_d);
    logic [XLEN-1:0] ea;
    logic            erw;
    logic [CL-1:0]   ed;
    int              w;
    won_d = model_pick_d(i_pend, d_pend);
    ea    = won_d ? req_d_addr : req_i_addr;
    erw   = won_d ? req_d_rw : 1'b0;
    ed    = won_d ? req_d_data : '0;
    w = 0;
    do begin
      @(negedge clk_i);
      w++;
    end while (bus.m_strobe_o !== 1'b1 && w < 16);
    tests_run++;
    if (w != 1) begin
      fails++;
      $display("FAIL grant_latency: m_strobe_o after %0d cycles, required 1", w);
    end
    tests_run++;
    if ({bus.m_addr_o, bus.m_rw_o} !== {ea, erw}) begin
      fails++;
      $display("FAIL grant_addr_rw: got addr=%h rw=%b, required addr=%h rw=%b (owner_d=%0b)",
               bus.m_addr_o, bus.m_rw_o, ea, erw, won_d);
    end
    tests_run++;
    if (bus.m_data_o !== ed) begin
      fails++;
      $display("FAIL grant_data: got %h, required %h", bus.m_data_o, ed);
    end
    // Requester inputs change after the grant; the memory side must not follow.
    if (won_d) begin
      bus.d_addr_i = ~req_d_addr;
      bus.d_rw_i   = ~req_d_rw;
      bus.d_data_i = ~req_d_data;
    end else begin
      bus.i_addr_i = ~req_i_addr;
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk_i);
      tests_run++;
      if ({bus.m_strobe_o, bus.m_addr_o, bus.m_rw_o, bus.m_data_o, bus.i_done_o, bus.d_done_o}
          !== {1'b1, ea, erw, ed, 2'b00}) begin
        fails++;
        $display("FAIL issue_hold: cycle %0d strobe=%b addr=%h rw=%b done=%b%b, required strobe=1 addr=%h rw=%b done=00",
                 k, bus.m_strobe_o, bus.m_addr_o, bus.m_rw_o, bus.i_done_o, bus.d_done_o, ea, erw);
      end
    end
    bus.m_done_i = 1'b1;
    bus.m_data_i = rd;
    @(negedge clk_i);
    bus.m_done_i = 1'b0;
    bus.m_data_i = ~rd;
    tests_run++;
    if ({bus.i_done_o, bus.d_done_o} !== {!won_d, won_d}) begin
      fails++;
      $display("FAIL done_owner: got i_done=%b d_done=%b, required i_done=%b d_done=%b",
               bus.i_done_o, bus.d_done_o, !won_d, won_d);
    end
    tests_run++;
    if ((won_d ? bus.d_data_o : bus.i_data_o) !== rd) begin
      fails++;
      $display("FAIL resp_data: got %h, required %h",
               won_d ? bus.d_data_o : bus.i_data_o, rd);
    end
    tests_run++;
    if (timeout_o !== exp_to) begin
      fails++;
      $display("FAIL timeout_flag: got %b, required %b", timeout_o, exp_to);
    end
    if (won_d) begin
      bus.d_strobe_i = 1'b0;
      d_pend         = 1'b0;
      last_d_rd      = rd;
    end else begin
      bus.i_strobe_i = 1'b0;
      i_pend         = 1'b0;
      last_i_rd      = rd;
    end
`ifdef MEM_ARB_RR_EN
    last_d = won_d;
`endif
    @(negedge clk_i);
    tests_run++;
    if ({bus.m_strobe_o, bus.i_done_o, bus.d_done_o} !== 3'b000) begin
      fails++;
      $display("FAIL done_single_pulse: strobe=%b i_done=%b d_done=%b, required 000",
               bus.m_strobe_o, bus.i_done_o, bus.d_done_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    tests_run++;
    if ({bus.m_strobe_o, bus.m_rw_o, bus.i_done_o, bus.d_done_o, timeout_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: strobe=%b rw=%b i_done=%b d_done=%b timeout=%b, required all 0",
               bus.m_strobe_o, bus.m_rw_o, bus.i_done_o, bus.d_done_o, timeout_o);
    end
    tests_run++;
    if (bus.m_addr_o !== '0) begin
      fails++;
      $display("FAIL reset_addr: got %h, required 0", bus.m_addr_o);
    end
    tests_run++;
    if ({bus.m_data_o, bus.i_data_o, bus.d_data_o} !== '0) begin
      fails++;
      $display("FAIL reset_data: m_data=%h i_data=%h d_data=%h, required 0",
               bus.m_data_o, bus.i_data_o, bus.d_data_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_i_read();
    bit w;
    raise_i(64'h8000_0040);
    serve_one(5, {32{8'hA5}}, w);
  endtask

  task automatic test_d_write();
    bit w;
    raise_d(64'h8000_1000, 1'b1, {16{16'h1234}});
    serve_one(4, rand_line(), w);
  endtask

  // Both sides request together; the winner re-requests once immediately.
  task automatic test_simultaneous();
    bit       got [3];
    bit [2:0] exp_seq;
`ifdef MEM_ARB_RR_EN
    exp_seq = 3'b010;   // I, D, I (bit 0 is the first grant)
`else
    exp_seq = 3'b011;   // D, D, I
`endif
    raise_i(rand_addr());
    raise_d(rand_addr(), 1'b0, rand_line());
    serve_one(2, rand_line(), got[0]);
    if (got[0]) raise_d(rand_addr(), 1'b1, rand_line());
    else        raise_i(rand_addr());
    serve_one(2, rand_line(), got[1]);
    serve_one(2, rand_line(), got[2]);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got[k] !== exp_seq[k]) begin
        fails++;
        $display("FAIL tie_order: grant %0d went to %s, required %s",
                 k, got[k] ? "D" : "I", exp_seq[k] ? "D" : "I");
      end
    end
  endtask

  task automatic test_random();
    bit ip, dp, w;
    int guard;
    for (int r = 0; r < 40; r++) begin
      ip = 1'($urandom_range(0, 1));
      dp = ip ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ip) raise_i(rand_addr());
      if (dp) raise_d(rand_addr(), 1'($urandom_range(0, 1)), rand_line());
      guard = 0;
      while ((i_pend || d_pend) && guard < 4) begin
        serve_one($urandom_range(0, 6), rand_line(), w);
        guard++;
      end
    end
  endtask

  task automatic test_timeout();
    logic [CL-1:0] rd;
    int            w;
    rd = rand_line();
    raise_d(rand_addr(), 1'b0, rand_line());
    w = 0;
    do begin
      @(negedge clk_i);
      w++;
    end while (bus.m_strobe_o !== 1'b1 && w < 16);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk_i);
      tests_run++;
      if ({bus.m_strobe_o, timeout_o} !== {1'b1, (c >= TO) ? 1'b1 : 1'b0}) begin
        fails++;
        $display("FAIL watchdog: ISSUE cycle %0d strobe=%b timeout=%b, required strobe=1 timeout=%b",
                 c, bus.m_strobe_o, timeout_o, c >= TO);
      end
    end
    bus.m_done_i = 1'b1;
    bus.m_data_i = rd;
    @(negedge clk_i);
    bus.m_done_i = 1'b0;
    tests_run++;
    if ({bus.d_done_o, bus.i_done_o, timeout_o} !== 3'b101 || bus.d_data_o !== rd) begin
      fails++;
      $display("FAIL watchdog_complete: d_done=%b i_done=%b timeout=%b data=%h, required 1 0 1 data=%h",
               bus.d_done_o, bus.i_done_o, timeout_o, bus.d_data_o, rd);
    end
    bus.d_strobe_i = 1'b0;
    d_pend         = 1'b0;
    last_d_rd      = rd;
    exp_to         = 1'b1;
`ifdef MEM_ARB_RR_EN
    last_d = 1'b1;
`endif
    repeat (2) @(negedge clk_i);
    tests_run++;
    if ({timeout_o, bus.d_done_o} !== 2'b10) begin
      fails++;
      $display("FAIL watchdog_sticky: timeout=%b d_done=%b, required 1 0", timeout_o, bus.d_done_o);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit w;
    int n;
    raise_i(rand_addr());
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (bus.m_strobe_o !== 1'b1 && n < 16);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    tests_run++;
    if ({bus.m_strobe_o, bus.i_done_o, bus.d_done_o, timeout_o} !== 4'b0 ||
        bus.m_addr_o !== '0 || bus.i_data_o !== '0) begin
      fails++;
      $display("FAIL reset_mid_issue: strobe=%b i_done=%b d_done=%b timeout=%b addr=%h, required all 0",
               bus.m_strobe_o, bus.i_done_o, bus.d_done_o, timeout_o, bus.m_addr_o);
    end
    bus.i_strobe_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if ({bus.m_strobe_o, bus.i_done_o, bus.d_done_o} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release_idle: strobe=%b i_done=%b d_done=%b, required 000",
               bus.m_strobe_o, bus.i_done_o, bus.d_done_o);
    end
    raise_d(rand_addr(), 1'b1, rand_line());
    serve_one(3, rand_line(), w);
  endtask

  task automatic test_spurious_done();
    bit w;
    bus.m_done_i = 1'b1;
    bus.m_data_i = rand_line();
    @(negedge clk_i);
    bus.m_done_i = 1'b0;
    tests_run++;
    if ({bus.m_strobe_o, bus.i_done_o, bus.d_done_o} !== 3'b000 ||
        bus.i_data_o !== last_i_rd || bus.d_data_o !== last_d_rd) begin
      fails++;
      $display("FAIL spurious_done: strobe=%b i_done=%b d_done=%b i_data=%h d_data=%h, required 000 and data unchanged",
               bus.m_strobe_o, bus.i_done_o, bus.d_done_o, bus.i_data_o, bus.d_data_o);
    end
    @(negedge clk_i);
    raise_i(rand_addr());
    serve_one(2, rand_line(), w);
  endtask

  // Hard stop if the run ever wedges.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests_run);
    $fatal(1);
  end

  initial begin
    tests_run = 0;
    fails     = 0;
    model_reset();
    req_i_addr     = '0;
    req_d_addr     = '0;
    req_d_rw       = 1'b0;
    req_d_data     = '0;
    bus.i_strobe_i = 1'b0;
    bus.i_addr_i   = '0;
    bus.d_strobe_i = 1'b0;
    bus.d_addr_i   = '0;
    bus.d_rw_i     = 1'b0;
    bus.d_data_i   = '0;
    bus.m_done_i   = 1'b0;
    bus.m_data_i   = '0;

    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_random();
    test_timeout();
    test_reset_mid_issue();
    test_spurious_done();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
